// File: rtl/pill_count_display.sv
// Pill counter: counts pill-eaten collisions and shows the total (0..999)
// as three active-low seven-segment digits.
// Ports: CLOCK_50 clock, reset async active-high, collision_type[3:0] code
// (4'b0010 = pill), hex1/hex2/hex3 hundreds/tens/ones segments {g..a}.
// Optional macro PILL_LEADING_ZERO_BLANK_EN blanks leading zero digits.
module pill_count_display (
  input  logic       CLOCK_50,
  input  logic       reset,
  input  logic [3:0] collision_type,
  output logic [6:0] hex1,
  output logic [6:0] hex2,
  output logic [6:0] hex3
);

  typedef enum logic {
    HOLD = 1'b0,
    INCR = 1'b1
  } state_t;

  localparam logic [3:0] PILL_CODE = 4'b0010;
  localparam logic [9:0] CNT_MAX   = 10'd999;

  state_t     ps_q, ps_d;
  logic [9:0] cnt_q, cnt_d;

  logic [11:0] bcd_w;
  logic [3:0]  hund_w, tens_w, ones_w;
  logic        en1_w, en2_w, en3_w;

  // Shift-add-3: adjust each BCD nibble >= 5 before every shift.
  function automatic logic [11:0] bcd_3b(input logic [9:0] bin);
    logic [21:0] sh;
    sh = {12'd0, bin};
    for (int i = 0; i < 10; i++) begin
      if (sh[13:10] >= 4'd5) sh[13:10] = sh[13:10] + 4'd3;
      if (sh[17:14] >= 4'd5) sh[17:14] = sh[17:14] + 4'd3;
      if (sh[21:18] >= 4'd5) sh[21:18] = sh[21:18] + 4'd3;
      sh = sh << 1;
    end
    return sh[21:10];
  endfunction

  function automatic logic [6:0] hexto7segment(
    input logic [3:0] in,
    input logic       enable
  );
    logic [6:0] seg;
    unique case (in)
      4'h0: seg = 7'b1000000;
      4'h1: seg = 7'b1111001;
      4'h2: seg = 7'b0100100;
      4'h3: seg = 7'b0110000;
      4'h4: seg = 7'b0011001;
      4'h5: seg = 7'b0010010;
      4'h6: seg = 7'b0000010;
      4'h7: seg = 7'b1111000;
      4'h8: seg = 7'b0000000;
      4'h9: seg = 7'b0010000;
      4'hA: seg = 7'b0001000;
      4'hB: seg = 7'b0000011;
      4'hC: seg = 7'b1000110;
      4'hD: seg = 7'b0100001;
      4'hE: seg = 7'b0000110;
      4'hF: seg = 7'b0001110;
      default: seg = 7'b1111111;
    endcase
    return enable ? seg : 7'b1111111;
  endfunction

  always_ff @(posedge CLOCK_50 or posedge reset) begin
    if (reset) begin
      ps_q  <= HOLD;
      cnt_q <= '0;
    end else begin
      ps_q  <= ps_d;
      cnt_q <= cnt_d;
    end
  end

  // INCR lasts exactly one cycle, so a held pill code
  // counts once every two cycles.
  always_comb begin
    ps_d  = ps_q;
    cnt_d = cnt_q;
    unique case (ps_q)
      HOLD: begin
        if (collision_type == PILL_CODE) ps_d = INCR;
      end
      INCR: begin
        ps_d = HOLD;
        if (cnt_q != CNT_MAX) cnt_d = cnt_q + 10'd1;
      end
      default: ps_d = HOLD;
    endcase
  end

  always_comb begin
    bcd_w  = bcd_3b(cnt_q);
    hund_w = bcd_w[11:8];
    tens_w = bcd_w[7:4];
    ones_w = bcd_w[3:0];
  end

`ifdef PILL_LEADING_ZERO_BLANK_EN
  assign en1_w = (hund_w != 4'd0);
  assign en2_w = (hund_w != 4'd0) || (tens_w != 4'd0);
  assign en3_w = 1'b1;
`else
  assign en1_w = 1'b1;
  assign en2_w = 1'b1;
  assign en3_w = 1'b1;
`endif

  assign hex1 = hexto7segment(hund_w, en1_w);
  assign hex2 = hexto7segment(tens_w, en2_w);
  assign hex3 = hexto7segment(ones_w, en3_w);

endmodule

// File: tb/tb_pill_count_display.sv
// Self-checking bench for pill_count_display using an expected-display
// scoreboard queue fed by a behavioural count model.
module tb_pill_count_display;

  logic       CLOCK_50;
  logic       reset;
  logic [3:0] collision_type;
  logic [6:0] hex1, hex2, hex3;

  int checks = 0;
  int failures = 0;

  logic [20:0] exp_q[$];

  // Behavioural model state
  bit m_incr;
  int m_cnt;

  logic [6:0] seg_tab [10];

  pill_count_display dut (
    .CLOCK_50       (CLOCK_50),
    .reset          (reset),
    .collision_type (collision_type),
    .hex1           (hex1),
    .hex2           (hex2),
    .hex3           (hex3)
  );

  initial CLOCK_50 = 1'b0;
  always #5 CLOCK_50 = ~CLOCK_50;

  task automatic chk(input string tag, input logic [20:0] got,
                     input logic [20:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %b_%b_%b expected %b_%b_%b", tag,
               got[20:14], got[13:7], got[6:0],
               exp[20:14], exp[13:7], exp[6:0]);
    end
  endtask

  function automatic logic [20:0] disp(input int cnt);
    int h, t, o;
    logic [6:0] s1, s2, s3;
    h  = cnt / 100;
    t  = (cnt / 10) % 10;
    o  = cnt % 10;
    s1 = seg_tab[h];
    s2 = seg_tab[t];
    s3 = seg_tab[o];
`ifdef PILL_LEADING_ZERO_BLANK_EN
    if (h == 0) s1 = 7'b1111111;
    if (h == 0 && t == 0) s2 = 7'b1111111;
`endif
    return {s1, s2, s3};
  endfunction

  // Drive one cycle of stimulus, predict, then compare after the edge.
  task automatic step(input logic [3:0] code, input string tag);
    logic [20:0] e;
    collision_type = code;
    if (m_incr) begin
      if (m_cnt < 999) m_cnt++;
      m_incr = 1'b0;
    end else begin
      m_incr = (code == 4'b0010);
    end
    exp_q.push_back(disp(m_cnt));
    @(posedge CLOCK_50);
    #1;
    if (exp_q.size() == 0) begin
      chk({tag, "_empty"}, {hex1, hex2, hex3}, 21'h1FFFFF ^ {hex1, hex2, hex3});
    end else begin
      e = exp_q.pop_front();
      chk(tag, {hex1, hex2, hex3}, e);
    end
  endtask

  task automatic do_reset();
    reset = 1'b1;
    collision_type = 4'b0000;
    m_incr = 1'b0;
    m_cnt = 0;
    exp_q.delete();
    repeat (2) begin
      @(posedge CLOCK_50);
      #1;
      chk("reset", {hex1, hex2, hex3}, disp(0));
    end
    reset = 1'b0;
  endtask

  initial begin
    seg_tab = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
                7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
                7'b0000000, 7'b0010000};
    reset = 1'b1;
    collision_type = 4'b0000;
    #2;
    chk("async_reset0", {hex1, hex2, hex3}, disp(0));

    do_reset();
    chk("zero_disp", {hex1, hex2, hex3},
        {7'b1000000, 7'b1000000, 7'b1000000} |
`ifdef PILL_LEADING_ZERO_BLANK_EN
        {7'b1111111, 7'b1111111, 7'b0000000}
`else
        21'd0
`endif
        );

    // Pill for 2 cycles then ignored code for 2 cycles
    step(4'b0010, "pill_a0");
    step(4'b0010, "pill_a1");
    step(4'b0110, "ign_a0");
    step(4'b0110, "ign_a1");

    // Held pill: counts once every two cycles
    for (int i = 0; i < 6; i++) step(4'b0010, "held");

    // Random codes
    for (int i = 0; i < 40; i++)
      step(4'($urandom_range(0, 15)), "rand");

    // Run to saturation and beyond
    for (int i = 0; i < 2000; i++) step(4'b0010, "to999");
    chk("sat999", {hex1, hex2, hex3},
        {7'b0010000, 7'b0010000, 7'b0010000});
    for (int i = 0; i < 10; i++) step(4'b0010, "hold999");

    // Count to 10, then reset mid-cycle during INCR
    do_reset();
    for (int i = 0; i < 20; i++) step(4'b0010, "to10");
    step(4'b0010, "enter_incr");
    #3;
    reset = 1'b1;
    #1;
    m_incr = 1'b0;
    m_cnt = 0;
    chk("reset_mid_incr", {hex1, hex2, hex3}, disp(0));
    reset = 1'b0;
    step(4'b0000, "post_rst0");
    step(4'b0000, "post_rst1");

    // Count 5 and 105 (embedded zero / blanking cases)
    for (int i = 0; i < 10; i++) step(4'b0010, "to5");
    chk("cnt5", {hex1, hex2, hex3}, disp(5));
    for (int i = 0; i < 200; i++) step(4'b0010, "to105");
    chk("cnt105", {hex1, hex2, hex3}, disp(105));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
